// File: rtl/flexbex_ibex_prefetch_req_if.sv
// ---------------------------------------------------------------------------
// flexbex_ibex_prefetch_req_if
//
// Purpose:
//   Bundles the two handshake buses of the instruction-fetch request engine.
//   - The instruction-memory request/response bus (req/gnt/rvalid).
//   - The push port into the fetch FIFO (valid/ready plus address and data).
//
// Modports:
//   master : used by the fetch engine. It drives the memory request and the
//            FIFO push, and receives gnt/rvalid/rdata and the FIFO ready.
//   slave  : used by the environment (memory plus FIFO). It is the mirror
//            image of master.
//
// Signals:
//   instr_req_o / instr_addr_o      memory request and word address
//   instr_gnt_i                     request accepted
//   instr_rvalid_i / instr_rdata_i  in-order response, one per grant
//   fifo_valid_o / fifo_ready_i     push handshake into the fetch FIFO
//   fifo_addr_o / fifo_rdata_o      address and data of the pushed word
//   fifo_clear_o                    flush the fetch FIFO (branch)
//
// Optional feature macro: FLEXBEX_FETCH_ERR_EN
//   When defined, two extra signals are added:
//   - instr_err_i qualifies rvalid with a bus error.
//   - fifo_err_o tags the pushed word as erroneous.
// ---------------------------------------------------------------------------
interface flexbex_ibex_prefetch_req_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
`ifdef FLEXBEX_FETCH_ERR_EN
    logic        instr_err_i;
    logic        fifo_err_o;
`endif
    logic        fifo_valid_o;
    logic        fifo_ready_i;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_clear_o;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_gnt_i,
        input  instr_rvalid_i,
        input  instr_rdata_i,
`ifdef FLEXBEX_FETCH_ERR_EN
        input  instr_err_i,
        output fifo_err_o,
`endif
        output fifo_valid_o,
        input  fifo_ready_i,
        output fifo_addr_o,
        output fifo_rdata_o,
        output fifo_clear_o
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_gnt_i,
        output instr_rvalid_i,
        output instr_rdata_i,
`ifdef FLEXBEX_FETCH_ERR_EN
        output instr_err_i,
        input  fifo_err_o,
`endif
        input  fifo_valid_o,
        output fifo_ready_i,
        input  fifo_addr_o,
        input  fifo_rdata_o,
        input  fifo_clear_o
    );
endinterface

// File: rtl/flexbex_ibex_prefetch_req.sv
// ---------------------------------------------------------------------------
// flexbex_ibex_prefetch_req
//
// Purpose:
//   Instruction-fetch request engine. It issues word-aligned sequential
//   fetches on the instruction-memory bus and tracks how many are in flight.
//   Returned words are pushed into the fetch FIFO. When the FIFO stalls, they
//   are held in a small skid buffer. On a branch, in-flight responses are
//   squashed and fetching restarts at the branch target.
//
// Parameters:
//   MAX_OUTSTANDING  Limit on in-flight requests plus buffered skid words
//                    (1..4). This is also the skid depth.
//
// Ports:
//   clk, rst        Clock. Synchronous active-high reset.
//   req_i           Fetch enable. Low stops new requests from being raised.
//   branch_i        One-cycle redirect pulse.
//   branch_addr_i   Redirect target. Bit 1 marks a halfword-aligned target.
//   busy_o          Requests in flight, or words sitting in the skid.
//   bus             Memory and FIFO push handshakes (master modport).
//
// Optional feature macro: FLEXBEX_FETCH_ERR_EN
//   When defined:
//   - bus.instr_err_i tags a response as a bus error.
//   - The word is pushed with bus.fifo_err_o set.
//   - Fetching stalls until the next branch.
//   When undefined, all responses are treated as good.
// ---------------------------------------------------------------------------
module flexbex_ibex_prefetch_req #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_i,
    input  logic                               branch_i,
    input  logic [31:0]                        branch_addr_i,
    output logic                               busy_o,
    flexbex_ibex_prefetch_req_if.master        bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] MAX_SUM  = SUM_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_addr_q, fetch_addr_d;
    logic [31:0]        resp_addr_q, resp_addr_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [CNT_W-1:0]   skid_count_q, skid_count_d;
    logic [PTR_W-1:0]   skid_rd_q, skid_rd_d;
    logic [PTR_W-1:0]   skid_wr_q, skid_wr_d;
    logic               target_valid_q, target_valid_d;
    logic [31:0]        skid_addr_q [MAX_OUTSTANDING];
    logic [31:0]        skid_data_q [MAX_OUTSTANDING];
`ifdef FLEXBEX_FETCH_ERR_EN
    logic               skid_err_q [MAX_OUTSTANDING];
    logic               err_block_q, err_block_d;
`endif

    logic               req_active;
    logic               gnt_fire;
    logic               rvalid_live;
    logic               resp_keep;
    logic               skid_empty;
    logic               pass_through;
    logic               skid_push;
    logic               skid_pop;
    logic               issue_ok;
    logic               resp_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Handshake qualification.
    // A response that arrives while nothing is outstanding is stray traffic
    // left over from before a reset, so it is ignored. A response seen in the
    // branch cycle belongs to the old stream and is never kept.
    always_comb begin
        req_active   = (state_q == REQ);
        gnt_fire     = req_active & bus.instr_gnt_i;
        rvalid_live  = bus.instr_rvalid_i & (outstanding_q != '0);
        resp_keep    = rvalid_live & (discard_q == '0) & ~branch_i;
        skid_empty   = (skid_count_q == '0);
        pass_through = resp_keep & skid_empty & bus.fifo_ready_i;
        skid_push    = resp_keep & ~pass_through;
        skid_pop     = ~skid_empty & bus.fifo_ready_i & ~branch_i;
`ifdef FLEXBEX_FETCH_ERR_EN
        resp_err     = bus.instr_err_i;
`else
        resp_err     = 1'b0;
`endif
    end

    // FIFO push port.
    // The skid head has priority, so words leave in arrival order. A fresh
    // response bypasses combinationally only when the skid is empty.
    always_comb begin
        bus.fifo_clear_o = branch_i;
        bus.fifo_valid_o = ~branch_i & (~skid_empty | pass_through);
        bus.fifo_addr_o  = skid_empty ? resp_addr_q : skid_addr_q[skid_rd_q];
        bus.fifo_rdata_o = skid_empty ? bus.instr_rdata_i : skid_data_q[skid_rd_q];
`ifdef FLEXBEX_FETCH_ERR_EN
        bus.fifo_err_o   = skid_empty ? bus.instr_err_i : skid_err_q[skid_rd_q];
`endif
        bus.instr_req_o  = req_active;
        bus.instr_addr_o = fetch_addr_q;
        busy_o           = (outstanding_q != '0) | ~skid_empty;
    end

    // Datapath next state: addresses, in-flight and discard counters, skid pointers.
    // A branch overrides everything else. Every request still in flight after
    // the branch cycle, including one granted in that very cycle, becomes a
    // word to discard.
    always_comb begin
        fetch_addr_d   = fetch_addr_q;
        resp_addr_d    = resp_addr_q;
        target_valid_d = target_valid_q | branch_i;
        outstanding_d  = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rvalid_live);
        discard_d      = discard_q;
        skid_rd_d      = skid_rd_q;
        skid_wr_d      = skid_wr_q;
        skid_count_d   = skid_count_q + CNT_W'(skid_push) - CNT_W'(skid_pop);
`ifdef FLEXBEX_FETCH_ERR_EN
        err_block_d    = err_block_q | (resp_keep & resp_err);
`endif

        if (gnt_fire) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end
        if (rvalid_live && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (resp_keep) begin
            resp_addr_d = {resp_addr_q[31:2] + 30'd1, 2'b00};
        end
        if (skid_push) begin
            skid_wr_d = ptr_inc(skid_wr_q);
        end
        if (skid_pop) begin
            skid_rd_d = ptr_inc(skid_rd_q);
        end

        if (branch_i) begin
            fetch_addr_d = {branch_addr_i[31:2], 2'b00};
            resp_addr_d  = branch_addr_i;
            discard_d    = outstanding_d;
            skid_rd_d    = '0;
            skid_wr_d    = '0;
            skid_count_d = '0;
`ifdef FLEXBEX_FETCH_ERR_EN
            err_block_d  = 1'b0;
`endif
        end
    end

    // Request FSM.
    // The credit check uses next-cycle occupancy, so a freshly raised request
    // always fits in the skid once it returns. A raised but ungranted request
    // is never withdrawn. A branch only changes the address it carries.
    always_comb begin
        issue_ok = req_i & target_valid_d
                 & ((SUM_W'(outstanding_d) + SUM_W'(skid_count_d)) < MAX_SUM);
`ifdef FLEXBEX_FETCH_ERR_EN
        issue_ok = issue_ok & ~err_block_d;
`endif
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue_ok) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (gnt_fire && !issue_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers. Reset drops every in-flight and buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            fetch_addr_q   <= '0;
            resp_addr_q    <= '0;
            outstanding_q  <= '0;
            discard_q      <= '0;
            skid_count_q   <= '0;
            skid_rd_q      <= '0;
            skid_wr_q      <= '0;
            target_valid_q <= 1'b0;
`ifdef FLEXBEX_FETCH_ERR_EN
            err_block_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            fetch_addr_q   <= fetch_addr_d;
            resp_addr_q    <= resp_addr_d;
            outstanding_q  <= outstanding_d;
            discard_q      <= discard_d;
            skid_count_q   <= skid_count_d;
            skid_rd_q      <= skid_rd_d;
            skid_wr_q      <= skid_wr_d;
            target_valid_q <= target_valid_d;
`ifdef FLEXBEX_FETCH_ERR_EN
            err_block_q    <= err_block_d;
`endif
        end
    end

    // Skid storage.
    // Only entries between the read and write pointers are meaningful, so the
    // payload needs no reset.
    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_addr_q[skid_wr_q] <= resp_addr_q;
            skid_data_q[skid_wr_q] <= bus.instr_rdata_i;
`ifdef FLEXBEX_FETCH_ERR_EN
            skid_err_q[skid_wr_q]  <= resp_err;
`endif
        end
    end

endmodule

// File: tb/tb_flexbex_ibex_prefetch_req.sv
`timescale 1ns/1ps
module tb_flexbex_ibex_prefetch_req;

    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        busy_o;

    logic        gnt_en;
    logic        rv_en;
    logic        ready_en;

    int num_checks = 0;
    int num_errors = 0;

    // Addresses granted by the memory and not yet returned, oldest first
    logic [31:0] mem_q[$];
    logic [31:0] push_addr_log[$];
    logic [31:0] push_data_log[$];
    logic        push_err_log[$];
    logic [31:0] grant_log[$];
    logic [31:0] err_addr;

    // Model state: what must happen according to the fetch rules
    int          m_out;
    int          m_held;
    int          m_discard;
    logic        m_have_target;
    logic [31:0] m_fetch;
    logic [31:0] m_push_addr;
    logic        m_err_block;
    logic        m_prev_pending;
    logic        m_prev_branch;
    logic [31:0] m_prev_addr;
    logic        m_grant;
    logic        m_rvalid;
    logic        m_push;
    logic        m_avail;

    flexbex_ibex_prefetch_req_if bus ();

    flexbex_ibex_prefetch_req #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .busy_o        (busy_o),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr_gnt_i  = gnt_en;
    assign bus.fifo_ready_i = ready_en;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'd0, actual}, {31'd0, expected});
    endtask

    function automatic logic [31:0] logAt(input int which, input int idx);
        if (which == 0) return (push_addr_log.size() > idx) ? push_addr_log[idx] : 32'hDEAD_BEEF;
        if (which == 1) return (push_data_log.size() > idx) ? push_data_log[idx] : 32'hDEAD_BEEF;
        return (grant_log.size() > idx) ? grant_log[idx] : 32'hDEAD_BEEF;
    endfunction

    // Memory responder: one response per grant, one cycle after it
    always @(posedge clk) begin
        #2;
        bus.instr_rvalid_i = rv_en && !rst && (mem_q.size() > 0);
        bus.instr_rdata_i  = bus.instr_rvalid_i ? memWord(mem_q[0]) : 32'd0;
`ifdef FLEXBEX_FETCH_ERR_EN
        bus.instr_err_i    = bus.instr_rvalid_i && (mem_q[0] == err_addr);
`endif
    end

    // Compare process: check outputs mid-cycle against the model, then advance the model
    always @(negedge clk) begin
        if (rst) begin
            mem_q.delete();
            m_out = 0; m_held = 0; m_discard = 0; m_have_target = 1'b0;
            m_fetch = 32'd0; m_push_addr = 32'd0; m_err_block = 1'b0;
            m_prev_pending = 1'b0; m_prev_branch = 1'b0; m_prev_addr = 32'd0;
        end else begin
            m_grant  = bus.instr_req_o & bus.instr_gnt_i;
            m_rvalid = bus.instr_rvalid_i;
            m_push   = bus.fifo_valid_o & bus.fifo_ready_i;
            m_avail  = (m_held != 0) || (m_rvalid && m_discard == 0);

            checkBit("clear_eq_branch", bus.fifo_clear_o, branch_i);
            if (branch_i) checkBit("no_push_on_branch", bus.fifo_valid_o, 1'b0);
            checkBit("busy", busy_o, (m_out != 0) || (m_held != 0));
            checkBit("credit_limit", (m_out + m_held) <= MAX_OUT, 1'b1);
            if (!m_have_target) checkBit("no_fetch_before_boot", bus.instr_req_o, 1'b0);
            if (m_prev_pending) begin
                checkBit("req_held", bus.instr_req_o, 1'b1);
                if (!m_prev_branch) checkOutput("addr_held", bus.instr_addr_o, m_prev_addr);
            end
            if (m_err_block && !m_prev_pending) checkBit("err_no_new_req", bus.instr_req_o, 1'b0);
            if (m_grant) begin
                checkOutput("fetch_addr", bus.instr_addr_o, m_fetch);
                grant_log.push_back(bus.instr_addr_o);
            end
            if (m_push) begin
                checkBit("push_has_data", m_avail, 1'b1);
                checkOutput("push_addr", bus.fifo_addr_o, m_push_addr);
                checkOutput("push_data", bus.fifo_rdata_o, memWord({m_push_addr[31:2], 2'b00}));
                push_addr_log.push_back(bus.fifo_addr_o);
                push_data_log.push_back(bus.fifo_rdata_o);
`ifdef FLEXBEX_FETCH_ERR_EN
                checkBit("push_err", bus.fifo_err_o, {m_push_addr[31:2], 2'b00} == err_addr);
                push_err_log.push_back(bus.fifo_err_o);
`else
                push_err_log.push_back(1'b0);
`endif
            end

            m_prev_pending = bus.instr_req_o & ~bus.instr_gnt_i;
            m_prev_branch  = branch_i;
            m_prev_addr    = bus.instr_addr_o;

            if (m_rvalid) begin
                m_out--;
                if (m_discard != 0) m_discard--;
                else if (!branch_i) begin
                    m_held++;
`ifdef FLEXBEX_FETCH_ERR_EN
                    if (bus.instr_err_i) m_err_block = 1'b1;
`endif
                end
                void'(mem_q.pop_front());
            end
            if (m_grant) begin
                m_out++;
                m_fetch = m_fetch + 32'd4;
                mem_q.push_back(bus.instr_addr_o);
            end
            if (m_push) begin
                m_held--;
                m_push_addr = {m_push_addr[31:2] + 30'd1, 2'b00};
            end
            if (branch_i) begin
                m_discard     = m_out;
                m_held        = 0;
                m_fetch       = {branch_addr_i[31:2], 2'b00};
                m_push_addr   = branch_addr_i;
                m_have_target = 1'b1;
                m_err_block   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of control inputs; a branch is always a single-cycle pulse
    task automatic applyStimulus(input logic req, input logic br, input logic [31:0] baddr);
        req_i         = req;
        branch_i      = br;
        branch_addr_i = baddr;
        tick();
        branch_i      = 1'b0;
    endtask

    task automatic clearLogs();
        push_addr_log.delete();
        push_data_log.delete();
        push_err_log.delete();
        grant_log.delete();
    endtask

    task automatic drainAll();
        req_i    = 1'b0;
        gnt_en   = 1'b1;
        rv_en    = 1'b1;
        ready_en = 1'b1;
        for (int i = 0; i < 60 && (busy_o || bus.instr_req_o); i++) tick();
        checkBit("drain_done", busy_o | bus.instr_req_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gcount;
        rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'd0;
        gnt_en = 1'b1; rv_en = 1'b1; ready_en = 1'b1;
        err_addr = 32'h0000_0804;
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = 32'd0;
`ifdef FLEXBEX_FETCH_ERR_EN
        bus.instr_err_i    = 1'b0;
`endif
        repeat (2) tick();
        $display("[TB] reset checks");
        checkBit("reset_instr_req", bus.instr_req_o, 1'b0);
        checkBit("reset_fifo_valid", bus.fifo_valid_o, 1'b0);
        checkBit("reset_busy", busy_o, 1'b0);
        rst = 1'b0;
        req_i = 1'b1;
        repeat (4) tick();
        checkBit("idle_without_boot_branch", bus.instr_req_o, 1'b0);

        $display("[TB] boot fetch from 0x100");
        clearLogs();
        applyStimulus(1'b1, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 40 && (push_addr_log.size() < 3 || grant_log.size() < 3); i++) tick();
        checkBit("boot_progress", push_addr_log.size() >= 3 && grant_log.size() >= 3, 1'b1);
        checkOutput("boot_grant0", logAt(2, 0), 32'h0000_0100);
        checkOutput("boot_grant1", logAt(2, 1), 32'h0000_0104);
        checkOutput("boot_grant2", logAt(2, 2), 32'h0000_0108);
        checkOutput("boot_push0_addr", logAt(0, 0), 32'h0000_0100);
        checkOutput("boot_push0_data", logAt(1, 0), 32'h5A5A_A4A5);
        checkOutput("boot_push1_data", logAt(1, 1), 32'h5A5A_A4A1);
        checkOutput("boot_push2_addr", logAt(0, 2), 32'h0000_0108);
        checkOutput("boot_push2_data", logAt(1, 2), 32'h5A5A_A4AD);
        drainAll();

        $display("[TB] halfword branch to 0x202");
        clearLogs();
        req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h0000_0202;
        #3;
        checkBit("clear_in_branch_cycle", bus.fifo_clear_o, 1'b1);
        @(posedge clk); #1;
        branch_i = 1'b0;
        #2;
        checkBit("clear_after_branch", bus.fifo_clear_o, 1'b0);
        for (int i = 0; i < 40 && push_addr_log.size() < 2; i++) tick();
        checkOutput("hw_push0_addr", logAt(0, 0), 32'h0000_0202);
        checkOutput("hw_push0_data", logAt(1, 0), 32'h5A5A_A7A5);
        checkOutput("hw_push1_addr", logAt(0, 1), 32'h0000_0204);
        checkOutput("hw_push1_data", logAt(1, 1), 32'h5A5A_A7A1);
        drainAll();

        $display("[TB] FIFO stall fills the skid");
        clearLogs();
        ready_en = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h0000_0300);
        repeat (6) tick();
        checkBit("stall_no_req", bus.instr_req_o, 1'b0);
        checkBit("stall_busy", busy_o, 1'b1);
        checkBit("stall_head_valid", bus.fifo_valid_o, 1'b1);
        checkOutput("stall_head_addr", bus.fifo_addr_o, 32'h0000_0300);
        checkOutput("stall_no_push", push_addr_log.size(), 32'd0);
        ready_en = 1'b1;
        tick();
        checkOutput("skid_pop1_count", push_addr_log.size(), 32'd1);
        tick();
        checkOutput("skid_pop2_count", push_addr_log.size(), 32'd2);
        checkOutput("skid_pop1_addr", logAt(0, 1), 32'h0000_0304);
        for (int i = 0; i < 10 && !bus.instr_req_o; i++) tick();
        checkBit("req_resumes", bus.instr_req_o, 1'b1);
        drainAll();

        $display("[TB] branch squashes two pending responses");
        clearLogs();
        rv_en = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h0000_0400);
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) tick();
        checkOutput("two_pending", mem_q.size(), 32'd2);
        checkBit("credit_blocks_req", bus.instr_req_o, 1'b0);
        clearLogs();
        applyStimulus(1'b1, 1'b1, 32'h0000_0500);
        rv_en = 1'b1;
        for (int i = 0; i < 20 && push_addr_log.size() < 1; i++) tick();
        checkOutput("squash_push0_addr", logAt(0, 0), 32'h0000_0500);
        checkOutput("squash_push0_data", logAt(1, 0), 32'h5A5A_A0A5);
        drainAll();

        $display("[TB] withheld grant and retarget");
        gnt_en = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h0000_0600);
        checkBit("stall_req_c1", bus.instr_req_o, 1'b1);
        checkOutput("stall_addr_c1", bus.instr_addr_o, 32'h0000_0600);
        tick();
        checkOutput("stall_addr_c2", bus.instr_addr_o, 32'h0000_0600);
        tick();
        checkOutput("stall_addr_c3", bus.instr_addr_o, 32'h0000_0600);
        applyStimulus(1'b1, 1'b1, 32'h0000_0700);
        checkBit("retarget_req", bus.instr_req_o, 1'b1);
        checkOutput("retarget_addr", bus.instr_addr_o, 32'h0000_0700);
        tick();
        checkOutput("retarget_addr_held", bus.instr_addr_o, 32'h0000_0700);
        drainAll();

        $display("[TB] address wrap");
        clearLogs();
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 40 && (push_addr_log.size() < 2 || grant_log.size() < 2); i++) tick();
        checkOutput("wrap_grant0", logAt(2, 0), 32'hFFFF_FFFC);
        checkOutput("wrap_grant1", logAt(2, 1), 32'h0000_0000);
        checkOutput("wrap_push0_data", logAt(1, 0), 32'hA5A5_5A59);
        checkOutput("wrap_push1_addr", logAt(0, 1), 32'h0000_0000);
        checkOutput("wrap_push1_data", logAt(1, 1), 32'h5A5A_A5A5);
        drainAll();

`ifdef FLEXBEX_FETCH_ERR_EN
        $display("[TB] error response blocks fetch");
        clearLogs();
        applyStimulus(1'b1, 1'b1, 32'h0000_0800);
        for (int i = 0; i < 40 && push_addr_log.size() < 2; i++) tick();
        checkBit("err_push0_flag", (push_err_log.size() > 0) ? push_err_log[0] : 1'b1, 1'b0);
        checkBit("err_push1_flag", (push_err_log.size() > 1) ? push_err_log[1] : 1'b0, 1'b1);
        repeat (8) tick();
        checkBit("err_req_stopped", bus.instr_req_o, 1'b0);
        gcount = grant_log.size();
        repeat (5) tick();
        checkOutput("err_no_grants", grant_log.size(), gcount);
        clearLogs();
        applyStimulus(1'b1, 1'b1, 32'h0000_0900);
        for (int i = 0; i < 20 && grant_log.size() < 1; i++) tick();
        checkOutput("err_branch_resumes", logAt(2, 0), 32'h0000_0900);
        drainAll();
`else
        gcount = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/flexbex_ibex_prefetch_req.md
Name: flexbex_ibex_prefetch_req

Overview:
Instruction-fetch request engine that drives the core's instruction-memory interface (req/gnt/rvalid) and pushes returned words into the fetch FIFO's input port.
- Issues word-aligned sequential fetches and tracks outstanding requests.
- Absorbs responses in a local skid buffer when the FIFO stalls.
- Squashes in-flight responses on a branch.
- Sits between the IF-stage control and the fetch FIFO. It is the producer end of that FIFO's in_valid/in_ready/in_addr/in_rdata interface.

Parameters:
MAX_OUTSTANDING, 2, maximum granted-but-unreturned requests plus skid entries (1..4).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high; sampled on rising clk
req_i  in  1  fetch enable; low stops issuing new requests
branch_i  in  1  redirect fetch, one-cycle pulse
branch_addr_i  in  32  redirect target; bit 1 set means the target is a halfword-aligned instruction
instr_req_o  out  1  memory request
instr_addr_o  out  32  memory word address, bits [1:0] always 00
instr_gnt_i  in  1  request accepted
instr_rvalid_i  in  1  response valid; in order; one per grant
instr_rdata_i  in  32  response data
fifo_valid_o  out  1  push valid to fetch FIFO
fifo_ready_i  in  1  fetch FIFO can accept (its in_ready)
fifo_addr_o  out  32  address of the pushed word
fifo_rdata_o  out  32  pushed word
fifo_clear_o  out  1  flush the fetch FIFO
busy_o  out  1  outstanding requests or skid entries non-zero

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: instr_req_o=0, fifo_valid_o=0, busy_o=0.
  - Registers: fetch_addr=0, resp_addr=0, outstanding=0, discard=0, skid emptied.
  - Reset mid-transaction drops all state. Responses arriving after reset are ignored while discard=0 and outstanding=0; the memory system is reset with the core.
- No fetch occurs until the first branch_i, which supplies the boot address.
- State machine:
  - IDLE: instr_req_o=0. Go to REQ when req_i=1, a valid target is held, and outstanding+skid_count < MAX_OUTSTANDING.
  - REQ: instr_req_o=1, instr_addr_o=fetch_addr. Hold the address stable until gnt.
    - On gnt: outstanding+1 and fetch_addr+4, with wrap at 2^32 (0xFFFFFFFC -> 0).
    - After gnt, stay in REQ if the issue condition still holds and req_i=1; otherwise go to IDLE.
    - Once instr_req_o is high without gnt, it must not drop, except that branch_i retargets it.
- Credit rule: never raise a new request unless outstanding+skid_count < MAX_OUTSTANDING. This guarantees the skid can never overflow.
- Response path:
  - On instr_rvalid_i: outstanding-1.
  - If discard>0: drop the word and decrement discard.
  - Otherwise: when the skid is empty and fifo_ready_i=1, pass through combinationally (fifo_valid_o=1, same cycle). Else write into the skid.
- Skid:
  - FIFO order, depth MAX_OUTSTANDING. The head drives fifo_*_o when non-empty.
  - Pop when fifo_valid_o & fifo_ready_i.
  - Simultaneous pop and push preserves order.
- fifo_addr_o:
  - Carries resp_addr, stored per entry in the skid.
  - The first accepted word after a branch carries branch_addr_i[1:0] exactly. Later words carry the word address, with resp_addr += 4 aligned: resp_addr <= {resp_addr[31:2]+1, 2'b00}.
- branch_i:
  - fifo_clear_o = branch_i, combinational, the same cycle.
  - Skid is cleared. fifo_valid_o is forced 0 in that cycle.
  - fetch_addr <= {branch_addr_i[31:2], 2'b00}; resp_addr <= branch_addr_i.
  - discard <= outstanding + (instr_req_o & instr_gnt_i) − (instr_rvalid_i & discard==0 ? 1 : 0) + (existing discard adjustment).
  - A same-cycle rvalid is dropped; a same-cycle gnt counts toward discard.
  - An ungranted pending request is retargeted the next cycle.
  - While discard>0, new requests may still issue. Credits count discard-pending requests as outstanding.
- busy_o = (outstanding != 0) | skid non-empty.

Optional Feature:
- Macro FLEXBEX_FETCH_ERR_EN.
- When defined:
  - Adds port instr_err_i (in, 1; qualifies rvalid) and port fifo_err_o (out, 1).
  - An error response is pushed with fifo_err_o=1 and is not dropped.
  - After an error, no new requests issue until the next branch_i.
- When undefined: no such ports, and all responses are treated as good.

Test Plan:
- Reset, branch_i to 0x0000_0100, req_i=1, gnt every cycle, rvalid 1 cycle later, fifo_ready_i=1 -> instr_addr_o 0x100, 0x104, 0x108. fifo_addr_o 0x100, 0x104, 0x108 with matching rdata. Never more than 2 outstanding.
- Branch to 0x0000_0202 -> first push fifo_addr_o=0x202 with data from word 0x200, next push 0x204. fifo_clear_o high exactly in the branch cycle.
- fifo_ready_i=0 with 2 outstanding -> both responses held in skid, instr_req_o stays 0. Raise ready -> pushes in order on consecutive cycles, then requests resume.
- Branch while 2 granted responses are pending -> both responses dropped, no fifo_valid_o. The first push is the branch target word.
- gnt withheld 5 cycles -> instr_req_o=1 and instr_addr_o stable throughout. Branch in cycle 3 -> address changes to the new target the next cycle.
- fetch_addr 0xFFFF_FFFC granted -> next instr_addr_o=0x0000_0000. With FLEXBEX_FETCH_ERR_EN: err response -> fifo_err_o=1 on that push and no further requests until branch.
